vdp_cpu_vram_port: RTL and testbench
====================================

Name: vdp_cpu_vram_port

Overview:
- CPU-side front end for VRAM access, directly upstream of the VRAM access arbiter.
- Decodes CPU accesses to data port (0) and control port (1) into the arbiter's toggle handshakes: write, read, and address-set requests.
- Captures read-ahead data returned from VRAM into a one-byte latch and presents it on the next data-port read.
- Decodes two-byte control sequences into either a VRAM address set or a register-write strobe.

Parameters:
- FIFO_DEPTH, 4, write-buffer entries; used only with CPU_WRITE_FIFO_EN; power of two, 2..8.

Ports:
- CLK21M  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- DOTSTATE  in  2  dot phase; VRAM read data is valid when 2'b01
- cpu_req  in  1  one-cycle CPU access strobe
- cpu_wr  in  1  1 = write, 0 = read
- cpu_port  in  2  0 = data, 1 = control/status; 2 and 3 are ignored
- cpu_dbo  in  8  CPU write data
- cpu_dbi  out  8  read-ahead latch contents
- cpu_wait  out  1  CPU stall request
- reg_r14  in  3  VRAM address bits 16:14
- RAMDBI  in  8  VRAM read data
- VDPVRAMWRACK, VDPVRAMRDACK, VDPVRAMADDRSETACK  in  1 each  arbiter ack toggles
- VDPVRAMREADINGR  in  1  arbiter read-issued toggle
- VDPVRAMWRREQ, VDPVRAMRDREQ, VDPVRAMADDRSETREQ  out  1 each  request toggles
- VDPVRAMREADINGA  out  1  read-captured toggle
- VDPVRAMACCESSADDRTMP  out  17  pending address
- VDPVRAMACCESSDATA  out  8  write byte
- reg_wr_en  out  1  one-cycle register-write strobe
- reg_num  out  6  register number
- reg_data  out  8  register value

Behaviour:
- Reset: every output is 0. This includes all toggles, the latch, ADDRTMP, first_byte_pending and cpu_wait.
- Handshake:
  - A request is pending while REQ != ACK.
  - Issuing a request inverts REQ.
  - REQ is never inverted again while that request is still pending.
- Control write, first byte (first_byte_pending = 0): store cpu_dbo in byte1; set first_byte_pending = 1.
- Control write, second byte: clear first_byte_pending, then decode cpu_dbo:
  - bit7 = 1: in the next cycle pulse reg_wr_en for exactly 1 cycle, with reg_num = cpu_dbo[5:0] and reg_data = byte1.
  - bit7 = 0: set ADDRTMP = {reg_r14, cpu_dbo[5:0], byte1} and invert ADDRSETREQ. If bit6 = 0, also invert RDREQ in the same cycle, starting a prefetch.
- Any data-port access, and any control-port read, clears first_byte_pending.
- Data write: set VDPVRAMACCESSDATA = cpu_dbo and invert WRREQ.
- Data read: cpu_dbi already holds the latch. Invert RDREQ to prefetch the next byte. The arbiter increments the address.
- Read capture: when VDPVRAMREADINGR != VDPVRAMREADINGA and DOTSTATE == 2'b01, latch RAMDBI and set READINGA = READINGR. This has 1-cycle latency.
- cpu_wait:
  - Asserted combinationally on cpu_req while a conflicting request is pending:
    - a data write while a write is pending;
    - a data read or an address set while RDREQ, WRREQ or ADDRSETREQ is pending.
  - The CPU holds cpu_req until cpu_wait deasserts.
  - The block accepts the access in the first cycle cpu_wait is low.
- Boundaries:
  - ADDRTMP bits 16:14 come from reg_r14 sampled at the second byte; later reg_r14 changes do not alter a pending address.
  - cpu_port 2 or 3: no state change.
  - Reset mid-handshake returns both sides to matched toggles, with nothing pending.

Optional Feature:
- CPU_WRITE_FIFO_EN defined:
  - Data writes enter a FIFO_DEPTH entry FIFO; cpu_wait on a write is asserted only when the FIFO is full.
  - The head entry drives VDPVRAMACCESSDATA and issues a WRREQ toggle when no write is pending; it pops when the matching ack arrives.
  - Reads and address sets wait until the FIFO is empty and no write is pending, so ordering is preserved.
  - When full and draining in the same cycle, a push is accepted.
- Undefined: a single write register, behaving as described in Behaviour.

Decomposition:
- Package vdp_cpu_port_pkg holds:
  - localparams PORT_DATA = 0 and PORT_CTRL = 1;
  - a typedef for the decoded control command (CMD_NONE, CMD_REGWR, CMD_ADDR_RD, CMD_ADDR_WR);
  - the READ_CAPTURE_DOTSTATE constant (2'b01).
- Sub-module vdp_cpu_wr_fifo holds the FIFO, with push/pop/full/empty; it is instantiated only under CPU_WRITE_FIFO_EN.

Test Plan:
- Register write: ctrl write 0x1F then 0x87 → reg_wr_en high for 1 cycle, reg_num = 7, reg_data = 0x1F; no request toggles.
- Address set for read: reg_r14 = 3, ctrl 0x34 then 0x12 → ADDRTMP = 0x0D234, ADDRSETREQ and RDREQ invert. Model arbiter acks, READINGR toggles, RAMDBI = 0xA5 at DOTSTATE 01 → cpu_dbi = 0xA5 and READINGA == READINGR.
- Address set for write: ctrl 0x00, 0x40 → ADDRTMP = {r14, 0x0000}, RDREQ unchanged. Data write 0x55 → DATA = 0x55, WRREQ inverts.
- Back-to-back writes with ack withheld: second write → cpu_wait held until ack, then DATA updates to the second byte. With FIFO enabled: 4 writes, no wait; the 5th waits.
- First-byte reset: ctrl 0x10, data-port read, ctrl 0x20, 0x40 → address-set ADDRTMP[7:0] = 0x20.
- Async RESET asserted with RDREQ pending → all outputs 0 immediately; first_byte_pending = 0.

Source files
------------

// File: rtl/vdp_cpu_vram_port_pkg.sv
// Shared definitions for the CPU-side VRAM port: port numbers, the
// decoded control-port command, the control-sequence state and the
// dot phase in which VRAM read data is valid.
package vdp_cpu_port_pkg;

  localparam logic [1:0] PORT_DATA = 2'd0;
  localparam logic [1:0] PORT_CTRL = 2'd1;

  // RAMDBI carries valid read data only in this dot phase
  localparam logic [1:0] READ_CAPTURE_DOTSTATE = 2'b01;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_REGWR,
    CMD_ADDR_RD,
    CMD_ADDR_WR
  } ctrl_cmd_t;

  // Two-byte control sequence: waiting for the first or the second byte
  typedef enum logic {
    CTRL_FIRST,
    CTRL_SECOND
  } ctrl_state_t;

  // Second control byte: bit7 selects register write, bit6 selects
  // address set for write (no prefetch) versus read (with prefetch).
  function automatic ctrl_cmd_t decode_ctrl(input logic [7:0] b);
    if (b[7]) begin
      return CMD_REGWR;
    end else if (b[6]) begin
      return CMD_ADDR_WR;
    end else begin
      return CMD_ADDR_RD;
    end
  endfunction

endpackage

// File: rtl/vdp_cpu_vram_port_if.sv
// CPU bus as seen by the VRAM port: a one-cycle access strobe with
// direction, port number and write data; read data and a stall back.
interface vdp_cpu_vram_port_if;
  logic       cpu_req;
  logic       cpu_wr;
  logic [1:0] cpu_port;
  logic [7:0] cpu_dbo;
  logic [7:0] cpu_dbi;
  logic       cpu_wait;

  modport master (
    output cpu_req, cpu_wr, cpu_port, cpu_dbo,
    input  cpu_dbi, cpu_wait
  );

  modport slave (
    input  cpu_req, cpu_wr, cpu_port, cpu_dbo,
    output cpu_dbi, cpu_wait
  );
endinterface

// File: rtl/vdp_cpu_wr_fifo.sv
// Small write-data FIFO between the CPU data port and the VRAM write
// handshake. DEPTH must be a power of two so the pointers wrap freely.
// A push while full is accepted when a pop happens in the same cycle.
module vdp_cpu_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             CLK21M,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr_reg];

  // Storage has no reset; only the pointers define what is valid
  always_ff @(posedge CLK21M) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
      else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
    end
  end
endmodule

// File: rtl/vdp_cpu_vram_port.sv
// CPU-side VRAM front end: turns CPU data/control port accesses into
// toggle handshakes toward the VRAM arbiter, keeps the one-byte
// read-ahead latch and decodes two-byte control sequences.
// Optional write buffering: define CPU_WRITE_FIFO_EN.
module vdp_cpu_vram_port
  import vdp_cpu_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK21M,
  input  logic                 RESET,
  input  logic [1:0]           DOTSTATE,
  vdp_cpu_vram_port_if.slave   cpu,
  input  logic [2:0]           reg_r14,
  input  logic [7:0]           RAMDBI,
  input  logic                 VDPVRAMWRACK,
  input  logic                 VDPVRAMRDACK,
  input  logic                 VDPVRAMADDRSETACK,
  input  logic                 VDPVRAMREADINGR,
  output logic                 VDPVRAMWRREQ,
  output logic                 VDPVRAMRDREQ,
  output logic                 VDPVRAMADDRSETREQ,
  output logic                 VDPVRAMREADINGA,
  output logic [16:0]          VDPVRAMACCESSADDRTMP,
  output logic [7:0]           VDPVRAMACCESSDATA,
  output logic                 reg_wr_en,
  output logic [5:0]           reg_num,
  output logic [7:0]           reg_data
);

  // Depth is only meaningful with write buffering; legal range 2..8, power of two
  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 8) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_fifo_depth_unsupported
  end

  ctrl_state_t ctrl_state_reg, ctrl_state_next;
  ctrl_cmd_t   ctrl_cmd;
  logic        byte1_load;

  logic [7:0]  byte1_reg;
  logic [7:0]  latch_reg;
  logic [7:0]  data_reg;
  logic [16:0] addr_reg;
  logic        wrreq_reg, rdreq_reg, asreq_reg, readinga_reg;
  logic        reg_wr_en_reg;
  logic [5:0]  reg_num_reg;
  logic [7:0]  reg_data_reg;

  logic wr_pend, rd_pend, as_pend, any_pend;
  logic is_data, is_ctrl;
  logic data_wr_req, data_rd_req, ctrl_wr_req, ctrl_rd_req;
  logic addr_set_req;
  logic wr_block, order_block;
  logic cpu_wait_int, accept;

  assign wr_pend  = wrreq_reg ^ VDPVRAMWRACK;
  assign rd_pend  = rdreq_reg ^ VDPVRAMRDACK;
  assign as_pend  = asreq_reg ^ VDPVRAMADDRSETACK;
  assign any_pend = wr_pend | rd_pend | as_pend;

  assign is_data     = (cpu.cpu_port == PORT_DATA);
  assign is_ctrl     = (cpu.cpu_port == PORT_CTRL);
  assign data_wr_req = cpu.cpu_req & is_data &  cpu.cpu_wr;
  assign data_rd_req = cpu.cpu_req & is_data & ~cpu.cpu_wr;
  assign ctrl_wr_req = cpu.cpu_req & is_ctrl &  cpu.cpu_wr;
  assign ctrl_rd_req = cpu.cpu_req & is_ctrl & ~cpu.cpu_wr;

  assign addr_set_req = (ctrl_cmd == CMD_ADDR_RD) || (ctrl_cmd == CMD_ADDR_WR);

`ifdef CPU_WRITE_FIFO_EN
  logic       fifo_full, fifo_empty, fifo_pop, fifo_push, wr_issue;
  logic       wr_issued_reg;
  logic [7:0] fifo_head;

  // Head goes out when no write is in flight; it leaves the FIFO on its ack
  assign wr_issue    = ~fifo_empty & ~wr_issued_reg & ~wr_pend;
  assign fifo_pop    = wr_issued_reg & ~wr_pend;
  assign fifo_push   = accept & data_wr_req;
  assign wr_block    = fifo_full & ~fifo_pop;
  // Reads and address sets must not overtake buffered writes
  assign order_block = ~fifo_empty | wr_issued_reg;

  vdp_cpu_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_wr_fifo (
    .CLK21M (CLK21M),
    .RESET  (RESET),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (cpu.cpu_dbo),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Write handshake driven from the FIFO head
  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      data_reg      <= '0;
      wrreq_reg     <= 1'b0;
      wr_issued_reg <= 1'b0;
    end else if (wr_issue) begin
      data_reg      <= fifo_head;
      wrreq_reg     <= ~wrreq_reg;
      wr_issued_reg <= 1'b1;
    end else if (fifo_pop) begin
      wr_issued_reg <= 1'b0;
    end
  end
`else
  assign wr_block    = wr_pend;
  assign order_block = 1'b0;

  // Single write register: each accepted data write starts one request
  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      data_reg  <= '0;
      wrreq_reg <= 1'b0;
    end else if (accept && data_wr_req) begin
      data_reg  <= cpu.cpu_dbo;
      wrreq_reg <= ~wrreq_reg;
    end
  end
`endif

  assign cpu_wait_int = (data_wr_req & wr_block) |
                        ((data_rd_req | addr_set_req) & (any_pend | order_block));
  assign accept       = cpu.cpu_req & ~cpu_wait_int;

  // Control-sequence state register
  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) ctrl_state_reg <= CTRL_FIRST;
    else       ctrl_state_reg <= ctrl_state_next;
  end

  // Next state: control writes alternate bytes; other port 0/1 accesses resync
  always_comb begin
    ctrl_state_next = ctrl_state_reg;
    if (accept) begin
      if (ctrl_wr_req) begin
        ctrl_state_next = (ctrl_state_reg == CTRL_FIRST) ? CTRL_SECOND : CTRL_FIRST;
      end else if (data_wr_req || data_rd_req || ctrl_rd_req) begin
        ctrl_state_next = CTRL_FIRST;
      end
    end
  end

  // Outputs: first-byte capture and the decoded second-byte command
  always_comb begin
    byte1_load = 1'b0;
    ctrl_cmd   = CMD_NONE;
    if (ctrl_wr_req) begin
      if (ctrl_state_reg == CTRL_FIRST) byte1_load = accept;
      else                              ctrl_cmd   = decode_ctrl(cpu.cpu_dbo);
    end
  end

  // First control byte holding register
  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET)           byte1_reg <= '0;
    else if (byte1_load) byte1_reg <= cpu.cpu_dbo;
  end

  // Address set and read prefetch requests
  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      addr_reg  <= '0;
      asreq_reg <= 1'b0;
      rdreq_reg <= 1'b0;
    end else if (accept && addr_set_req) begin
      addr_reg  <= {reg_r14, cpu.cpu_dbo[5:0], byte1_reg};
      asreq_reg <= ~asreq_reg;
      if (ctrl_cmd == CMD_ADDR_RD) rdreq_reg <= ~rdreq_reg;
    end else if (accept && data_rd_req) begin
      rdreq_reg <= ~rdreq_reg;
    end
  end

  // Register-write strobe, one cycle after the second control byte
  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      reg_wr_en_reg <= 1'b0;
      reg_num_reg   <= '0;
      reg_data_reg  <= '0;
    end else begin
      reg_wr_en_reg <= accept && (ctrl_cmd == CMD_REGWR);
      if (accept && (ctrl_cmd == CMD_REGWR)) begin
        reg_num_reg  <= cpu.cpu_dbo[5:0];
        reg_data_reg <= byte1_reg;
      end
    end
  end

  // Read-ahead capture once the arbiter has issued a read and data is valid
  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      latch_reg    <= '0;
      readinga_reg <= 1'b0;
    end else if ((VDPVRAMREADINGR != readinga_reg) && (DOTSTATE == READ_CAPTURE_DOTSTATE)) begin
      latch_reg    <= RAMDBI;
      readinga_reg <= VDPVRAMREADINGR;
    end
  end

  assign cpu.cpu_dbi          = latch_reg;
  assign cpu.cpu_wait         = cpu_wait_int;
  assign VDPVRAMWRREQ         = wrreq_reg;
  assign VDPVRAMRDREQ         = rdreq_reg;
  assign VDPVRAMADDRSETREQ    = asreq_reg;
  assign VDPVRAMREADINGA      = readinga_reg;
  assign VDPVRAMACCESSADDRTMP = addr_reg;
  assign VDPVRAMACCESSDATA    = data_reg;
  assign reg_wr_en            = reg_wr_en_reg;
  assign reg_num              = reg_num_reg;
  assign reg_data             = reg_data_reg;

endmodule

// File: tb/tb_vdp_cpu_vram_port.sv
// Bench for vdp_cpu_vram_port: directed CPU accesses push expected
// handshake events into per-kind queues; a monitor pops and compares
// each time the DUT toggles a request, captures, or strobes reg_wr_en.
module tb_vdp_cpu_vram_port;
  import vdp_cpu_port_pkg::*;

  logic        CLK21M = 1'b0;
  logic        RESET;
  logic [1:0]  DOTSTATE;
  logic [2:0]  reg_r14;
  logic [7:0]  RAMDBI;
  logic        wr_ack, rd_ack, as_ack, readingr;
  logic        WRREQ, RDREQ, ASREQ, READINGA;
  logic [16:0] ADDRTMP;
  logic [7:0]  DATA;
  logic        reg_wr_en;
  logic [5:0]  reg_num;
  logic [7:0]  reg_data;

  int errors = 0;
  int checks = 0;
  int w;

  logic [31:0] q_reg[$], q_addr[$], q_wr[$], q_rd[$], q_cap[$];

  vdp_cpu_vram_port_if bus ();

  vdp_cpu_vram_port #(.FIFO_DEPTH(4)) dut (
    .CLK21M               (CLK21M),
    .RESET                (RESET),
    .DOTSTATE             (DOTSTATE),
    .cpu                  (bus),
    .reg_r14              (reg_r14),
    .RAMDBI               (RAMDBI),
    .VDPVRAMWRACK         (wr_ack),
    .VDPVRAMRDACK         (rd_ack),
    .VDPVRAMADDRSETACK    (as_ack),
    .VDPVRAMREADINGR      (readingr),
    .VDPVRAMWRREQ         (WRREQ),
    .VDPVRAMRDREQ         (RDREQ),
    .VDPVRAMADDRSETREQ    (ASREQ),
    .VDPVRAMREADINGA      (READINGA),
    .VDPVRAMACCESSADDRTMP (ADDRTMP),
    .VDPVRAMACCESSDATA    (DATA),
    .reg_wr_en            (reg_wr_en),
    .reg_num              (reg_num),
    .reg_data             (reg_data)
  );

  always #5 CLK21M = ~CLK21M;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic pop_chk(input string name, inout logic [31:0] q[$], input logic [31:0] act);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event 0x%0h, expected none", name, act);
    end else begin
      chk(name, act, q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK21M);
  endtask

  // One CPU access, started on a negedge; held while cpu_wait is high
  task automatic cpu_access(input logic wr, input logic [1:0] port, input logic [7:0] d,
                            output int waits);
    waits = 0;
    bus.cpu_req  = 1'b1;
    bus.cpu_wr   = wr;
    bus.cpu_port = port;
    bus.cpu_dbo  = d;
    #1;
    while (bus.cpu_wait && waits < 60) begin
      @(negedge CLK21M);
      #1;
      waits++;
    end
    if (waits >= 60) chk("cpu_access_timeout", 32'(waits), 0);
    @(negedge CLK21M);
    bus.cpu_req = 1'b0;
  endtask

  task automatic wait_pending(input string name, ref logic req, ref logic ack);
    int n = 0;
    while (req == ack && n < 60) begin
      @(negedge CLK21M);
      n++;
    end
    if (n >= 60) chk(name, 32'(n), 0);
  endtask

  task automatic ack_wr();
    wait_pending("ack_wr_timeout", WRREQ, wr_ack);
    wr_ack = WRREQ;
    @(negedge CLK21M);
  endtask

  task automatic ack_as();
    wait_pending("ack_as_timeout", ASREQ, as_ack);
    as_ack = ASREQ;
    @(negedge CLK21M);
  endtask

  // Arbiter completes a read; with gated=1 the data phase is held off first
  task automatic ack_rd(input logic [7:0] v, input logic gated, input logic [7:0] old_dbi);
    wait_pending("ack_rd_timeout", RDREQ, rd_ack);
    rd_ack   = RDREQ;
    readingr = ~readingr;
    RAMDBI   = v;
    if (gated) begin
      DOTSTATE = 2'b00;
      idle(3);
      chk("no_capture_dot00", bus.cpu_dbi, old_dbi);
    end
    q_cap.push_back(32'(v));
    DOTSTATE = READ_CAPTURE_DOTSTATE;
    @(negedge CLK21M);
  endtask

  // Monitor: every toggle or strobe from the DUT consumes one expected event
  initial begin
    logic p_wr, p_rd, p_as, p_ra;
    p_wr = 0; p_rd = 0; p_as = 0; p_ra = 0;
    forever begin
      @(negedge CLK21M);
      if (!RESET) begin
        if (ASREQ != p_as)         pop_chk("ev_addrset", q_addr, {14'd0, ADDRTMP, RDREQ != p_rd});
        else if (RDREQ != p_rd)    pop_chk("ev_read", q_rd, 32'(ADDRTMP));
        if (WRREQ != p_wr)         pop_chk("ev_write", q_wr, 32'(DATA));
        if (READINGA != p_ra)      pop_chk("ev_capture", q_cap, 32'(bus.cpu_dbi));
        if (reg_wr_en)             pop_chk("ev_regwr", q_reg, {18'd0, reg_num, reg_data});
      end
      p_wr = WRREQ; p_rd = RDREQ; p_as = ASREQ; p_ra = READINGA;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; DOTSTATE = READ_CAPTURE_DOTSTATE; reg_r14 = 3'd0; RAMDBI = 8'h00;
    wr_ack = 0; rd_ack = 0; as_ack = 0; readingr = 0;
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_port = 2'd0; bus.cpu_dbo = 8'h00;
    idle(3);
    chk("rst_toggles", {28'd0, WRREQ, RDREQ, ASREQ, READINGA}, 0);
    chk("rst_addrtmp", 32'(ADDRTMP), 0);
    chk("rst_data", 32'(DATA), 0);
    chk("rst_dbi", 32'(bus.cpu_dbi), 0);
    chk("rst_wait", 32'(bus.cpu_wait), 0);
    chk("rst_regwr", {17'd0, reg_wr_en, reg_num, reg_data}, 0);
    RESET = 1'b0;
    idle(1);

    // Register write, with ignored port 2/3 accesses in between
    q_reg.push_back({18'd0, 6'd7, 8'h1F});
    cpu_access(1, PORT_CTRL, 8'h1F, w);
    cpu_access(1, 2'd2, 8'hAA, w);
    cpu_access(0, 2'd3, 8'h00, w);
    cpu_access(1, PORT_CTRL, 8'h87, w);
    chk("regwr_no_wait", 32'(w), 0);
    idle(3);
    chk("regwr_reqs_quiet", {29'd0, WRREQ, RDREQ, ASREQ}, 0);

    // Address set for read, then a data read stalled behind it
    reg_r14 = 3'd3;
    cpu_access(1, PORT_CTRL, 8'h34, w);
    q_addr.push_back({14'd0, 17'h0D234, 1'b1});
    cpu_access(1, PORT_CTRL, 8'h12, w);
    reg_r14 = 3'd5;
    idle(2);
    chk("addrtmp_r14_held", 32'(ADDRTMP), 32'h0D234);
    q_rd.push_back(32'h0D234);
    fork
      cpu_access(0, PORT_DATA, 8'h00, w);
      begin
        idle(3);
        chk("wait_rd_while_pending", 32'(bus.cpu_wait), 1);
        ack_as();
        ack_rd(8'hA5, 1'b1, 8'h00);
      end
    join
    chk("rd_waited", 32'(w != 0), 1);
    idle(2);
    chk("dbi_after_capture", 32'(bus.cpu_dbi), 32'hA5);
    chk("readinga_match", 32'(READINGA), 32'(readingr));
    ack_rd(8'h3C, 1'b0, 8'h00);
    idle(2);
    chk("dbi_prefetch", 32'(bus.cpu_dbi), 32'h3C);

    // Address set for write, then data writes
    cpu_access(1, PORT_CTRL, 8'h00, w);
    q_addr.push_back({14'd0, 17'h14000, 1'b0});
    cpu_access(1, PORT_CTRL, 8'h40, w);
    idle(1);
    chk("rdreq_unchanged", 32'(RDREQ), 32'(rd_ack));
    ack_as();
    q_wr.push_back(32'h55);
    cpu_access(1, PORT_DATA, 8'h55, w);
    chk("wr1_no_wait", 32'(w), 0);
`ifdef CPU_WRITE_FIFO_EN
    for (int i = 1; i <= 3; i++) begin
      q_wr.push_back(32'h60 + 32'(i));
      cpu_access(1, PORT_DATA, 8'h60 + 8'(i), w);
      chk("fifo_no_wait", 32'(w), 0);
    end
    q_wr.push_back(32'h64);
    fork
      cpu_access(1, PORT_DATA, 8'h64, w);
      begin
        idle(3);
        chk("wait_fifo_full", 32'(bus.cpu_wait), 1);
        repeat (5) ack_wr();
      end
    join
    chk("fifo5_waited", 32'(w != 0), 1);
    chk("data_last", 32'(DATA), 32'h64);
`else
    q_wr.push_back(32'h66);
    fork
      cpu_access(1, PORT_DATA, 8'h66, w);
      begin
        idle(3);
        chk("wait_wr_pending", 32'(bus.cpu_wait), 1);
        chk("data_held", 32'(DATA), 32'h55);
        ack_wr();
      end
    join
    chk("wr2_waited", 32'(w != 0), 1);
    chk("data_second", 32'(DATA), 32'h66);
    ack_wr();
`endif

    // Data-port read between control bytes restarts the sequence
    cpu_access(1, PORT_CTRL, 8'h10, w);
    q_rd.push_back(32'h14000);
    cpu_access(0, PORT_DATA, 8'h00, w);
    ack_rd(8'h77, 1'b0, 8'h00);
    cpu_access(1, PORT_CTRL, 8'h20, w);
    q_addr.push_back({14'd0, 17'h14020, 1'b0});
    cpu_access(1, PORT_CTRL, 8'h40, w);
    idle(2);
    chk("first_byte_resync", 32'(ADDRTMP[7:0]), 32'h20);
    ack_as();

    // Asynchronous reset with a read pending and a first byte held
    q_rd.push_back(32'h14020);
    cpu_access(0, PORT_DATA, 8'h00, w);
    cpu_access(1, PORT_CTRL, 8'h77, w);
    #2;
    RESET = 1'b1;
    wr_ack = 0; rd_ack = 0; as_ack = 0; readingr = 0;
    #1;
    chk("async_rst_rdreq", 32'(RDREQ), 0);
    chk("async_rst_outputs", {DATA, 7'd0, ADDRTMP}, 0);
    chk("async_rst_misc", {bus.cpu_dbi, WRREQ, ASREQ, READINGA, reg_wr_en}, 0);
    idle(2);
    RESET = 1'b0;
    idle(1);
    q_reg.push_back({18'd0, 6'd7, 8'h12});
    cpu_access(1, PORT_CTRL, 8'h12, w);
    cpu_access(1, PORT_CTRL, 8'h87, w);
    idle(3);
    chk("post_rst_no_reqs", {29'd0, WRREQ, RDREQ, ASREQ}, 0);

    chk("left_reg", 32'(q_reg.size()), 0);
    chk("left_addr", 32'(q_addr.size()), 0);
    chk("left_wr", 32'(q_wr.size()), 0);
    chk("left_rd", 32'(q_rd.size()), 0);
    chk("left_cap", 32'(q_cap.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
